// File: rtl/pe_nic.sv
// Network interface between a processing element and its local mesh-router port.
// One single-entry buffer per direction, accessed by the PE through a 2-bit register map.
module pe_nic #(
    parameter int DATA_WIDTH = 64,
    parameter int VC_BIT     = 63
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            addr,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic [DATA_WIDTH-1:0] d_out,
    input  logic                  nicEn,
    input  logic                  nicWrEn,
    input  logic                  net_si,
    output logic                  net_ri,
    input  logic [DATA_WIDTH-1:0] net_di,
    output logic                  net_so,
    input  logic                  net_ro,
    output logic [DATA_WIDTH-1:0] net_do,
    input  logic                  net_polarity
);

    localparam logic [1:0] ADDR_IN_BUF     = 2'b00;
    localparam logic [1:0] ADDR_IN_STATUS  = 2'b01;
    localparam logic [1:0] ADDR_OUT_BUF    = 2'b10;
    localparam logic [1:0] ADDR_OUT_STATUS = 2'b11;

    logic [DATA_WIDTH-1:0] in_buf;
    logic [DATA_WIDTH-1:0] out_buf;
    logic                  in_full;
    logic                  out_full;
    logic                  pe_rd;
    logic                  pe_wr;

    assign pe_rd = nicEn & ~nicWrEn;
    assign pe_wr = nicEn & nicWrEn;

    // A packet is only offered on the router phase that matches its VC bit.
    assign net_ri = ~in_full;
    assign net_so = out_full & net_ro & (out_buf[VC_BIT] == net_polarity);
    assign net_do = out_buf;

    // Arrival and PE drain need opposite values of in_full, so they never collide.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_buf  <= '0;
            in_full <= 1'b0;
        end else if (net_si && !in_full) begin
            in_buf  <= net_di;
            in_full <= 1'b1;
        end else if (pe_rd && (addr == ADDR_IN_BUF) && in_full) begin
            in_full <= 1'b0;
        end
    end

    // A write landing in the same cycle as the drain still sees out_full=1 and is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_buf  <= '0;
            out_full <= 1'b0;
        end else if (net_so) begin
            out_full <= 1'b0;
        end else if (pe_wr && (addr == ADDR_OUT_BUF) && !out_full) begin
            out_buf  <= d_in;
            out_full <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_out <= '0;
        end else if (pe_rd) begin
            case (addr)
                ADDR_IN_BUF:     d_out <= in_buf;
                ADDR_IN_STATUS:  d_out <= {{(DATA_WIDTH-1){1'b0}}, in_full};
                ADDR_OUT_BUF:    d_out <= out_buf;
                ADDR_OUT_STATUS: d_out <= {{(DATA_WIDTH-1){1'b0}}, out_full};
                default:         d_out <= d_out;
            endcase
        end
    end

endmodule

// File: doc/pe_nic.md
Name: pe_nic

Overview:
- Network interface controller between one processing element (PE) and its local PE port on the 4x4 mesh router.
- Exposes one single-entry input channel buffer and one single-entry output channel buffer to the PE through a 2-bit register address map.
- The output buffer feeds the router's PE input (pesi/pedi/peri side). The input buffer consumes the router's PE output (peso/pedo/pero side).
- Injection is gated by router polarity so that a packet only enters on its matching virtual channel phase.

Parameters:
- DATA_WIDTH, 64, packet and register width. Bit DATA_WIDTH-1 is the VC bit.
- VC_BIT, 63, index of the packet virtual-channel bit used for the polarity check.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- addr  input  2  PE register address: 00 in-buffer, 01 in-status, 10 out-buffer, 11 out-status.
- d_in  input  64  PE write data.
- d_out  output  64  PE read data (registered).
- nicEn  input  1  PE access enable.
- nicWrEn  input  1  1 = write, 0 = read; valid only with nicEn.
- net_si  input  1  router has a packet for this PE (router peso).
- net_ri  output  1  NIC can accept a packet (to router pero).
- net_di  input  64  packet from router (router pedo).
- net_so  output  1  NIC presents a packet (to router pesi).
- net_ro  input  1  router can accept (router peri).
- net_do  output  64  packet to router (to router pedi).
- net_polarity  input  1  router polarity.

Behaviour:
- State consists of in_buf[63:0], in_full, out_buf[63:0], out_full and d_out.
- Reset (asynchronous, reset=0):
  - in_full=0, out_full=0.
  - in_buf=0, out_buf=0, d_out=0.
  - Resulting outputs: net_so=0, net_do=0, net_ri=1.
  - Reset mid-transfer drops any buffered packet; nothing is retransmitted.
- Network receive:
  - net_ri = ~in_full (combinational).
  - At an edge with net_si=1 and in_full=0: in_buf<=net_di, in_full<=1.
  - net_si while in_full=1 is ignored; the router must hold the packet.
- Network send:
  - net_so = out_full & net_ro & (out_buf[VC_BIT]==net_polarity) (combinational).
  - net_do = out_buf at all times.
  - At an edge with net_so=1: out_full<=0. Single-cycle handshake; out_buf is retained but stale.
- PE write (nicEn=1, nicWrEn=1):
  - addr=10 with out_full=0: out_buf<=d_in, out_full<=1.
  - addr=10 with out_full=1: write ignored and the packet is not overwritten.
  - A write in the same cycle that net_so drains the buffer is also ignored, because out_full was 1 at that edge.
  - Writes to 00, 01 and 11 are ignored.
- PE read (nicEn=1, nicWrEn=0), one-cycle latency: d_out is updated at the edge.
  - addr 00: d_out<=in_buf. If in_full=1, in_full<=0 at the same edge.
  - A read of 00 while empty returns stale in_buf and leaves flags at 0.
  - addr 01: d_out<={63'b0,in_full}.
  - addr 10: d_out<=out_buf.
  - addr 11: d_out<={63'b0,out_full}.
  - With nicEn=0, d_out holds its value.
- Simultaneous events:
  - A PE read of 00 that empties in_buf and an arriving net_si in the same cycle: the arrival is refused because net_ri was 0 at that edge. The packet is accepted the following cycle.
  - Status reads return flag values from before the edge.
- No other state; no FSM beyond the two full flags.
- Implementation budget: about 150 RTL lines.

Test Plan:
1. Reset release, then read addr 01 and addr 11. Expected: d_out=0 for both, net_ri=1, net_so=0.
2. Write 64'h0000_0000_1111_1111 (VC=0) to addr 10 with net_ro=1.
   - With net_polarity=1: net_so stays 0.
   - After net_polarity goes to 0: net_so=1 for exactly one cycle and net_do=64'h0000_0000_1111_1111.
   - Next cycle: out_full=0 and a status read of 11 returns 0.
3. Write 64'h8000_0000_AAAA_AAAA and then immediately 64'h8000_0000_BBBB_BBBB to addr 10 with net_ro=0.
   - The second write is ignored.
   - After net_ro=1 and net_polarity=1: net_do=64'h8000_0000_AAAA_AAAA.
4. Drive net_si=1 with net_di=64'h0011_0101_5555_5555 for 2 cycles.
   - net_ri drops after the first edge.
   - Read of 01 returns 1. Read of 00 returns 64'h0011_0101_5555_5555, and in_full clears.
   - Second net_si is refused and accepted the cycle after the read.
5. Buffer a packet in out_buf and in in_buf, then assert reset=0 asynchronously mid-cycle.
   - Immediately: net_so=0, net_ri=1, d_out=0.
   - After reset: both status reads return 0.
6. Hold nicEn=0 while toggling addr and nicWrEn. Expected: d_out unchanged and no flag changes.
